bist6_engine: RTL and testbench
===============================

BIST6_ENGINE -- requirements
Module: bist6_engine

Interface
REQ-001 Parameter PAT_NUM, default 64, number of patterns applied per run (legal 1..64).
REQ-002 Parameter SETTLE, default 1, cycles between driving a pattern and sampling the response (legal 1..15).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-006 stim  output  6  pattern driven to the unit under test.
REQ-007 resp  input  6  response from the unit under test; expected value is the bitwise NOT of stim.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high while the run result is held.
REQ-010 pass  output  1  valid when done is high; 1 = all PAT_NUM patterns matched.
REQ-011 pass_cnt  output  7  number of patterns matched in the current or last run.
REQ-012 fail_idx  output  6  index of the first failing pattern; valid when done=1 and pass=0.
REQ-013 fail_exp  output  6  expected response at the first failure.
REQ-014 fail_got  output  6  sampled resp at the first failure.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, CHECK, DONE.
REQ-016 IDLE/DONE + start=1: go to SETTLE; clear idx, pass_cnt, pass and fail_*; set stim=0; load settle counter with SETTLE-1.
REQ-017 SETTLE: hold stim; decrement the settle counter each cycle; go to CHECK in the cycle after it reaches 0, so SETTLE lasts exactly SETTLE cycles.
REQ-018 CHECK: sample resp once and compare it against ~stim (6-bit bitwise NOT).
REQ-019 CHECK, match, idx<PAT_NUM-1: increment pass_cnt and idx; stim=idx+1; reload the settle counter; go to SETTLE.
REQ-020 CHECK, match, idx=PAT_NUM-1: increment pass_cnt; set pass=1; go to DONE.
REQ-021 CHECK, mismatch: capture fail_idx=idx, fail_exp=~stim, fail_got=resp; set pass=0; go to DONE; stop on first failure.
REQ-022 stim SHALL equal idx[5:0] throughout a run and hold its last value in DONE.
REQ-023 Each pattern SHALL occupy exactly SETTLE+1 cycles. With an all-pass run, done SHALL rise PAT_NUM*(SETTLE+1) cycles after the start-sampling edge.
REQ-024 busy SHALL be 1 exactly in SETTLE and CHECK. done SHALL be 1 exactly in DONE. busy and done SHALL never both be 1.
REQ-025 start during SETTLE or CHECK SHALL be ignored, with no effect on idx, stim or the result.
REQ-026 start in DONE SHALL launch a new run in the next cycle; done drops and busy rises on the same edge.
REQ-027 DONE SHALL hold pass, pass_cnt and fail_* stable until start or rst.
REQ-028 The 7-bit pass_cnt SHALL reach 64 at PAT_NUM=64 without wrapping.
REQ-029 idx SHALL never exceed PAT_NUM-1, with no wrap to 0 within a run.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, stim=0, busy=0, done=0, pass=0, pass_cnt=0, fail_idx=0, fail_exp=0, fail_got=0, and settle counter=0.
REQ-031 rst SHALL take priority over start and over any in-progress run. Reset mid-run SHALL abort with no result retained.
REQ-032 After rst is released, the block SHALL stay in IDLE until start=1.

Verification
REQ-033 Ideal NOT unit, PAT_NUM=64, SETTLE=1, pulse start -> stim steps 0..63, each held 2 cycles; done=1 at cycle 128; pass=1; pass_cnt=64.
REQ-034 Response with bit0 stuck-at-0 -> first mismatch at idx=0 (expected 111111, got 111110); done=1, pass=0, fail_idx=0, pass_cnt=0.
REQ-035 Response corrupted only when stim=37 -> fail_idx=37, fail_exp=011010, pass_cnt=37, stim held at 37.
REQ-036 start pulsed during a run at idx=10 -> no restart; run completes normally with pass_cnt=64.
REQ-037 rst asserted for 1 cycle at idx=20 -> all outputs 0 next cycle, state IDLE; a later start runs cleanly from stim=0.
REQ-038 PAT_NUM=1, SETTLE=3, ideal unit -> stim=0 for 4 cycles; done at cycle 4; pass=1; pass_cnt=1. Then start from DONE -> a second identical run.

Source files
------------

// File: rtl/bist6_engine.sv
// bist6_engine: 6-bit pattern BIST sequencer.
// Drives stim = idx and checks resp == ~stim after a settle window.
module bist6_engine #(
    parameter int PAT_NUM = 64,
    parameter int SETTLE  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [5:0] stim,
    input  logic [5:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] pass_cnt,
    output logic [5:0] fail_idx,
    output logic [5:0] fail_exp,
    output logic [5:0] fail_got
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(PAT_NUM - 1);
    localparam logic [3:0] SET_LD   = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] idx;
    logic [3:0] settle_cnt;
    logic       match;
    logic       last;

    // The pattern is the index itself, so stim always tracks idx.
    assign stim  = idx;
    assign match = (resp == ~idx);
    assign last  = (idx == LAST_IDX);

    // State register; reset overrides any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match && !last) begin
                    state_nxt = S_SETTLE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are pure functions of the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (1'b1)
            (state == S_SETTLE),
            (state == S_CHECK): busy = 1'b1;
            (state == S_DONE):  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Run datapath: index, settle timer, result and first-failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
            pass_cnt   <= '0;
            fail_idx   <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= SET_LD;
                        pass       <= 1'b0;
                        pass_cnt   <= '0;
                        fail_idx   <= '0;
                        fail_exp   <= '0;
                        fail_got   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        pass_cnt <= pass_cnt + 7'd1;
                        if (last) begin
                            pass <= 1'b1;
                        end else begin
                            idx        <= idx + 6'd1;
                            settle_cnt <= SET_LD;
                        end
                    end else begin
                        fail_idx <= idx;
                        fail_exp <= ~idx;
                        fail_got <= resp;
                        pass     <= 1'b0;
                    end
                end
                default: begin
                    idx <= idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist6_engine.sv
// tb_bist6_engine: directed bench with a cycle-level reference model.
// Two instances: 64 patterns / settle 1, and 1 pattern / settle 3.
`timescale 1ns/1ps
module tb_bist6_engine;

    typedef struct {
        bit         run;
        bit         done;
        bit         pass;
        int         t;
        logic [5:0] stim;
        logic [5:0] fi;
        logic [5:0] fe;
        logic [5:0] fg;
        logic [6:0] cnt;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    int         mode_a = 0;
    bit         chk_on = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic [5:0] stim_a, resp_a, fidx_a, fexp_a, fgot_a;
    logic       busy_a, done_a, pass_a;
    logic [6:0] cnt_a;
    logic [5:0] stim_b, resp_b, fidx_b, fexp_b, fgot_b;
    logic       busy_b, done_b, pass_b;
    logic [6:0] cnt_b;

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    always #5 clk = ~clk;

    // Emulated unit under test: ideal NOT with optional faults.
    function automatic logic [5:0] unit_resp(int mode, logic [5:0] s);
        logic [5:0] r;
        r = ~s;
        if (mode == 1) r[0] = 1'b0;
        else if (mode == 2 && s == 6'd37) r[0] = ~r[0];
        return r;
    endfunction

    assign resp_a = unit_resp(mode_a, stim_a);
    assign resp_b = unit_resp(0, stim_b);

    bist6_engine #(.PAT_NUM(64), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .pass_cnt(cnt_a), .fail_idx(fidx_a),
        .fail_exp(fexp_a), .fail_got(fgot_a)
    );

    bist6_engine #(.PAT_NUM(1), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .pass_cnt(cnt_b), .fail_idx(fidx_b),
        .fail_exp(fexp_b), .fail_got(fgot_b)
    );

    // Model: t counts cycles since launch; pattern k is checked
    // on the last cycle of its (ns+1)-cycle slot.
    function automatic mdl_t mstep(mdl_t m, int np, int ns, int mode,
                                   bit r, bit st);
        mdl_t n;
        int k;
        logic [5:0] want, got;
        n = m;
        if (r) begin
            n = '{default: 0};
        end else if (m.run) begin
            if (m.t % (ns + 1) == ns) begin
                k = m.t / (ns + 1);
                want = ~6'(k);
                got = unit_resp(mode, 6'(k));
                if (got == want) begin
                    n.cnt = m.cnt + 7'd1;
                    if (k == np - 1) begin
                        n.run = 0; n.done = 1; n.pass = 1;
                    end else begin
                        n.stim = 6'(k + 1);
                    end
                end else begin
                    n.fi = 6'(k); n.fe = want; n.fg = got;
                    n.run = 0; n.done = 1;
                end
            end
            n.t = m.t + 1;
        end else if (st) begin
            n = '{default: 0};
            n.run = 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma = mstep(ma, 64, 1, mode_a, rst, start_a);
        mb = mstep(mb, 1, 3, 0, rst, start_b);
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a.busy", busy_a, ma.run);
            chk("a.done", done_a, ma.done);
            chk("a.pass", pass_a, ma.pass);
            chk("a.stim", stim_a, ma.stim);
            chk("a.cnt", cnt_a, ma.cnt);
            chk("a.fidx", fidx_a, ma.fi);
            chk("a.fexp", fexp_a, ma.fe);
            chk("a.fgot", fgot_a, ma.fg);
            chk("b.busy", busy_b, mb.run);
            chk("b.done", done_b, mb.done);
            chk("b.pass", pass_b, mb.pass);
            chk("b.stim", stim_b, mb.stim);
            chk("b.cnt", cnt_b, mb.cnt);
            chk("a.excl", busy_a & done_a, 0);
        end
    end

    task automatic launch_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic launch_b();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        while (!done_a && cyc < 400) begin
            @(negedge clk); cyc++;
        end
    endtask

    task automatic wait_done_b(output int cyc);
        cyc = 0;
        while (!done_b && cyc < 400) begin
            @(negedge clk); cyc++;
        end
    endtask

    task automatic wait_stim_a(logic [5:0] v);
        int c;
        c = 0;
        while (stim_a != v && c < 400) begin
            @(negedge clk); c++;
        end
        chk("reach_idx", stim_a, v);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst.stim", stim_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.cnt", cnt_a, 0);
        repeat (5) @(negedge clk);
        chk("idle_hold", busy_a | done_a, 0);

        // Ideal unit, full 64-pattern run.
        launch_a(); wait_done_a(lat);
        chk("full.lat", lat, 128);
        chk("full.pass", pass_a, 1);
        chk("full.cnt", cnt_a, 64);
        chk("full.stim", stim_a, 63);

        // bit0 stuck-at-0, launched from DONE.
        mode_a = 1;
        launch_a(); wait_done_a(lat);
        chk("sa0.lat", lat, 2);
        chk("sa0.pass", pass_a, 0);
        chk("sa0.fidx", fidx_a, 0);
        chk("sa0.fexp", fexp_a, 6'b111111);
        chk("sa0.fgot", fgot_a, 6'b111110);
        chk("sa0.cnt", cnt_a, 0);

        // Corruption only at pattern 37.
        mode_a = 2;
        launch_a(); wait_done_a(lat);
        chk("p37.lat", lat, 76);
        chk("p37.fidx", fidx_a, 37);
        chk("p37.fexp", fexp_a, 6'b011010);
        chk("p37.fgot", fgot_a, 6'b011011);
        chk("p37.cnt", cnt_a, 37);
        chk("p37.stim", stim_a, 37);
        repeat (4) @(negedge clk);
        chk("p37.hold", fidx_a, 37);

        // Start pulse mid-run is ignored.
        mode_a = 0;
        launch_a(); wait_stim_a(6'd10);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_done_a(lat);
        chk("ign.cnt", cnt_a, 64);
        chk("ign.pass", pass_a, 1);

        // Reset mid-run aborts everything.
        launch_a(); wait_stim_a(6'd20);
        rst = 1'b1; @(negedge clk);
        chk("mrst.stim", stim_a, 0);
        chk("mrst.busy", busy_a, 0);
        chk("mrst.cnt", cnt_a, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst.idle", busy_a | done_a, 0);
        launch_a(); wait_done_a(lat);
        chk("rerun.lat", lat, 128);
        chk("rerun.cnt", cnt_a, 64);

        // Single pattern, settle 3, twice.
        for (int r = 0; r < 2; r++) begin
            launch_b(); wait_done_b(lat);
            chk("b.lat", lat, 4);
            chk("b.pass", pass_b, 1);
            chk("b.cnt1", cnt_b, 1);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
